// File: rtl/scmp_microcode_seq.sv
// SC/MP microcode sequencer: micro-PC next-address selection,
// DLY instruction cycle counter and memory-wait stall.
module scmp_microcode_seq #(
  parameter int UPC_W     = 6,
  parameter int FETCH_ADR = 0,
  parameter int DLY_W     = 18
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [UPC_W-1:0] op_pc_i,
  input  logic             op_dly_i,
  input  logic [1:0]       uc_nxt_i,
  input  logic             uc_cond_en_i,
  input  logic             cond_i,
  input  logic [UPC_W-1:0] uc_jmp_addr_i,
  input  logic             bus_wait_i,
  input  logic             dly_load_i,
  input  logic [7:0]       ac_i,
  input  logic [7:0]       disp_i,
  output logic [UPC_W-1:0] upc_o,
  output logic             dly_busy_o,
  output logic             is_dly_o,
  output logic             fetch_o
);

  typedef enum logic [1:0] {
    NXT_SEQ   = 2'd0,
    NXT_JMP   = 2'd1,
    NXT_DISP  = 2'd2,
    NXT_FETCH = 2'd3
  } nxt_e;

  localparam logic [UPC_W-1:0] FETCH_UPC = UPC_W'(FETCH_ADR);

  logic [UPC_W-1:0] upc_q, upc_d;
  logic [DLY_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             is_dly_q, is_dly_d;

  logic [UPC_W-1:0] upc_inc;
  logic [UPC_W-1:0] upc_sel;
  logic             is_dly_sel;
  logic             jmp_take;
  logic [DLY_W-1:0] dly_val;
  nxt_e             nxt;

  assign nxt      = nxt_e'(uc_nxt_i);
  assign upc_inc  = upc_q + UPC_W'(1);
  assign jmp_take = !uc_cond_en_i || cond_i;

  // 13 + 2*ac + 514*disp, with 514*disp split into shifts
  assign dly_val = DLY_W'(13)
                 + (DLY_W'(ac_i) << 1)
                 + (DLY_W'(disp_i) << 9)
                 + (DLY_W'(disp_i) << 1);

  always_comb begin
    upc_sel    = upc_inc;
    is_dly_sel = is_dly_q;
    unique case (nxt)
      NXT_SEQ: begin
        upc_sel = upc_inc;
      end
      NXT_JMP: begin
        upc_sel = jmp_take ? uc_jmp_addr_i : upc_inc;
      end
      NXT_DISP: begin
        upc_sel    = op_pc_i;
        is_dly_sel = op_dly_i;
      end
      NXT_FETCH: begin
        upc_sel    = FETCH_UPC;
        is_dly_sel = 1'b0;
      end
      default: begin
        upc_sel = upc_inc;
      end
    endcase
  end

  always_comb begin
    upc_d    = upc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    is_dly_d = is_dly_q;
    if (bus_wait_i) begin
      upc_d = upc_q;
    end else if (busy_q) begin
      // busy flag tracks the post-decrement count so it stays registered
      cnt_d  = cnt_q - DLY_W'(1);
      busy_d = (cnt_q != DLY_W'(1));
    end else begin
      upc_d    = upc_sel;
      is_dly_d = is_dly_sel;
      if (dly_load_i) begin
        cnt_d  = dly_val;
        busy_d = (dly_val != '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      upc_q    <= FETCH_UPC;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      is_dly_q <= 1'b0;
    end else begin
      upc_q    <= upc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      is_dly_q <= is_dly_d;
    end
  end

  assign upc_o      = upc_q;
  assign dly_busy_o = busy_q;
  assign is_dly_o   = is_dly_q;
  assign fetch_o    = (upc_q == FETCH_UPC);

endmodule

// File: tb/tb_scmp_microcode_seq.sv
// Bench for scmp_microcode_seq: directed literal checks plus
// randomized traffic compared every cycle to a behavioural model.
module tb_scmp_microcode_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] op_pc_i;
  logic       op_dly_i;
  logic [1:0] uc_nxt_i;
  logic       uc_cond_en_i;
  logic       cond_i;
  logic [5:0] uc_jmp_addr_i;
  logic       bus_wait_i;
  logic       dly_load_i;
  logic [7:0] ac_i;
  logic [7:0] disp_i;
  logic [5:0] upc_o;
  logic       dly_busy_o;
  logic       is_dly_o;
  logic       fetch_o;

  int errors = 0;
  int checks = 0;

  int m_upc;
  int m_cnt;
  int m_isdly;

  always #5 clk = ~clk;

  scmp_microcode_seq dut (
    .clk           (clk),
    .rst           (rst),
    .op_pc_i       (op_pc_i),
    .op_dly_i      (op_dly_i),
    .uc_nxt_i      (uc_nxt_i),
    .uc_cond_en_i  (uc_cond_en_i),
    .cond_i        (cond_i),
    .uc_jmp_addr_i (uc_jmp_addr_i),
    .bus_wait_i    (bus_wait_i),
    .dly_load_i    (dly_load_i),
    .ac_i          (ac_i),
    .disp_i        (disp_i),
    .upc_o         (upc_o),
    .dly_busy_o    (dly_busy_o),
    .is_dly_o      (is_dly_o),
    .fetch_o       (fetch_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: what one clock edge does to uPC, remaining delay and DLY flag.
  task automatic model_edge();
    if (rst) begin
      m_upc = 0; m_cnt = 0; m_isdly = 0;
    end else if (bus_wait_i) begin
      m_cnt = m_cnt;
    end else if (m_cnt > 0) begin
      m_cnt = m_cnt - 1;
    end else begin
      case (uc_nxt_i)
        2'd0: m_upc = (m_upc + 1) % 64;
        2'd1: m_upc = (!uc_cond_en_i || cond_i) ? int'(uc_jmp_addr_i)
                                                : (m_upc + 1) % 64;
        2'd2: begin m_upc = int'(op_pc_i); m_isdly = int'(op_dly_i); end
        default: begin m_upc = 0; m_isdly = 0; end
      endcase
      if (dly_load_i)
        m_cnt = 13 + 2 * int'(ac_i) + 514 * int'(disp_i);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("upc", int'(upc_o), m_upc);
    chk("busy", int'(dly_busy_o), int'(m_cnt != 0));
    chk("is_dly", int'(is_dly_o), m_isdly);
    chk("fetch", int'(fetch_o), int'(m_upc == 0));
  endtask

  task automatic idle_inputs();
    rst = 0; op_pc_i = 0; op_dly_i = 0; uc_nxt_i = 0;
    uc_cond_en_i = 0; cond_i = 0; uc_jmp_addr_i = 0;
    bus_wait_i = 0; dly_load_i = 0; ac_i = 0; disp_i = 0;
  endtask

  task automatic jmp(input int addr);
    uc_nxt_i = 2'd1; uc_cond_en_i = 0; uc_jmp_addr_i = 6'(addr);
    cyc();
  endtask

  // Load a delay, then count busy cycles (waits injected at wait_at).
  task automatic run_delay(input int ac, input int disp,
                           input int wait_at, output int n);
    uc_nxt_i = 2'd0; dly_load_i = 1; ac_i = 8'(ac); disp_i = 8'(disp);
    cyc();
    dly_load_i = 0;
    n = 0;
    while (dly_busy_o && n < 140000) begin
      bus_wait_i = (wait_at >= 0 && n >= wait_at && n < wait_at + 4);
      // stray strobes and next-fields during busy must be ignored
      dly_load_i = (n == 7);
      ac_i = 8'hff; disp_i = 8'hff;
      uc_nxt_i = 2'($urandom_range(0, 3));
      cyc();
      n++;
    end
    bus_wait_i = 0; dly_load_i = 0;
  endtask

  initial begin
    int n;
    idle_inputs();
    m_upc = 0; m_cnt = 0; m_isdly = 0;
    @(negedge clk);
    rst = 1;
    cyc();
    chk("rst_upc", int'(upc_o), 0);
    chk("rst_fetch", int'(fetch_o), 1);
    chk("rst_busy", int'(dly_busy_o), 0);
    chk("rst_isdly", int'(is_dly_o), 0);
    rst = 0;

    jmp(63);
    chk("jmp63", int'(upc_o), 63);
    uc_nxt_i = 2'd0; cyc();
    chk("seq_wrap", int'(upc_o), 0);

    jmp(5);
    uc_nxt_i = 2'd1; uc_cond_en_i = 1; cond_i = 0; uc_jmp_addr_i = 20;
    cyc();
    chk("jmp_nt", int'(upc_o), 6);
    jmp(5);
    uc_nxt_i = 2'd1; uc_cond_en_i = 1; cond_i = 1; uc_jmp_addr_i = 20;
    cyc();
    chk("jmp_t", int'(upc_o), 20);
    uc_cond_en_i = 0; cond_i = 0;

    uc_nxt_i = 2'd2; op_pc_i = 37; op_dly_i = 1; cyc();
    chk("disp_upc", int'(upc_o), 37);
    chk("disp_isdly", int'(is_dly_o), 1);
    op_dly_i = 0;
    uc_nxt_i = 2'd3; cyc();
    chk("fetch_upc", int'(upc_o), 0);
    chk("fetch_isdly", int'(is_dly_o), 0);

    run_delay(0, 0, -1, n);
    chk("dly_min_len", n, 13);
    chk("dly_min_upc", int'(upc_o), 1);
    run_delay(3, 1, -1, n);
    chk("dly_533_len", n, 533);
    run_delay(3, 1, 100, n);
    chk("dly_wait_len", n, 537);

    // max load: a counter narrower than 18 bits would end by ~521
    uc_nxt_i = 2'd0; dly_load_i = 1; ac_i = 255; disp_i = 255;
    cyc();
    dly_load_i = 0;
    repeat (700) cyc();
    chk("dly_max_busy", int'(dly_busy_o), 1);
    rst = 1; cyc(); rst = 0;

    uc_nxt_i = 2'd0; dly_load_i = 1; ac_i = 3; disp_i = 1;
    cyc();
    dly_load_i = 0;
    repeat (433) cyc();
    rst = 1; cyc(); rst = 0;
    chk("rst_mid_busy", int'(dly_busy_o), 0);
    chk("rst_mid_upc", int'(upc_o), 0);

    repeat (4000) begin
      rst = ($urandom_range(0, 199) == 0);
      bus_wait_i = ($urandom_range(0, 5) == 0);
      uc_nxt_i = 2'($urandom_range(0, 3));
      uc_cond_en_i = 1'($urandom);
      cond_i = 1'($urandom);
      uc_jmp_addr_i = 6'($urandom);
      op_pc_i = 6'($urandom);
      op_dly_i = 1'($urandom);
      dly_load_i = ($urandom_range(0, 39) == 0);
      ac_i = 8'($urandom);
      disp_i = 8'($urandom_range(0, 1));
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
